// File: rtl/calc_accum_seq_pkg.sv
// Shared definitions for the chained hex calculator: operation codes and
// the controller state type.
package calc_pkg;

  // Operation encodings carried on the 3-bit func input.
  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_MUL = 3'b010;
  localparam logic [2:0] FN_DIV = 3'b011;
  localparam logic [2:0] FN_MOD = 3'b100;
  localparam logic [2:0] FN_SQR = 3'b101;
  localparam logic [2:0] FN_CLR = 3'b110;
  localparam logic [2:0] FN_RSV = 3'b111;

  // Controller states: wait for a press, execute, iterate the divider,
  // commit the divider output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/calc_accum_seq_if.sv
// Front-panel bus of the calculator: button, operation select, operands
// and the accumulator/status read back by the display path.
interface calc_accum_seq_if #(
  parameter int W  = 8,
  parameter int RW = 32
);

  logic          button;
  logic [2:0]    func;
  logic [W-1:0]  num1;
  logic [W-1:0]  num2;
  logic [RW-1:0] result;
  logic          busy;
  logic          chain;
  logic          err_div0;
  logic          ovf;

  // Panel side: drives the controls, observes the accumulator.
  modport master (
    output button, func, num1, num2,
    input  result, busy, chain, err_div0, ovf
  );

  // Calculator side.
  modport slave (
    input  button, func, num1, num2,
    output result, busy, chain, err_div0, ovf
  );

endinterface

// File: rtl/calc_accum_seq_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debouncer and
// rising-edge press pulse. Also used for the display mode buttons.
module btn_debounce #(
  parameter int DEB_CYCLES = 150000
) (
  input  logic clk_g,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic          sync_a;
  logic          sync_b;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  // NOTE: clocked state uses <= so every flop samples the pre-edge value;
  // with = the second stage would copy the first in the same edge.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Toggle the debounced level only after an unbroken run of differing cycles.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_b != level) begin
      if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed copy of the level for edge detection.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/calc_accum_seq.sv
// Chained calculator: one operation per debounced press, accumulating into
// result. Single-cycle add/sub/mul/square; div/mod on a restoring
// shift-subtract divider taking one quotient bit per cycle.
module calc_accum_seq
  import calc_pkg::*;
#(
  parameter int W          = 8,
  parameter int RW         = 32,
  parameter int DEB_CYCLES = 150000
) (
  input logic             clk_g,
  input logic             rst_n,
  calc_accum_seq_if.slave bus
);

  localparam int PW = 2 * RW;
  localparam int CW = $clog2(RW + 1);

  state_t        state;
  logic [2:0]    op;
  logic [RW-1:0] opa;
  logic [RW-1:0] opb;
  logic [RW-1:0] quo;
  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [RW-1:0] result;
  logic          chain;
  logic          err_div0;
  logic          ovf;

  logic          btn_level;
  logic          press;
  logic          accept;
  logic [RW-1:0] a_sel;
  logic [RW:0]   sum;
  logic [PW-1:0] prod;
  logic [RW:0]   shifted;
  logic [RW:0]   diff;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk_g   (clk_g),
    .rst_n   (rst_n),
    .btn_raw (bus.button),
    .level   (btn_level),
    .press   (press)
  );

  // A press only counts while the debounced level is high and we are idle.
  assign accept = press && btn_level && (state == ST_IDLE);

  // First op of a chain takes num1; later ops reuse the accumulator.
  assign a_sel = chain ? result : RW'(bus.num1);

  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign prod = PW'(opa) * PW'(opb);

  // Restoring divider step: bring in the next dividend bit, try subtracting.
  assign shifted = {rem, quo[RW-1]};
  assign diff    = shifted - {1'b0, opb};

  // Controller and datapath; reset aborts any divide in flight.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op       <= FN_ADD;
      opa      <= '0;
      opb      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      result   <= '0;
      chain    <= 1'b0;
      err_div0 <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= bus.func;
            opa   <= a_sel;
            // Square is a multiply of A by itself.
            opb   <= (bus.func == FN_SQR) ? a_sel : RW'(bus.num2);
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state <= ST_IDLE;
          case (op)
            FN_ADD: begin
              result <= sum[RW-1:0];
              chain  <= 1'b1;
              if (sum[RW]) ovf <= 1'b1;
            end
            FN_SUB: begin
              result <= opa - opb;
              chain  <= 1'b1;
              if (opa < opb) ovf <= 1'b1;
            end
            FN_MUL, FN_SQR: begin
              result <= prod[RW-1:0];
              chain  <= 1'b1;
              if (|prod[PW-1:RW]) ovf <= 1'b1;
            end
            FN_DIV, FN_MOD: begin
              if (opb == '0) begin
                err_div0 <= 1'b1;
                chain    <= 1'b1;
              end else begin
                rem   <= '0;
                quo   <= opa;
                cnt   <= '0;
                state <= ST_DIV;
              end
            end
            FN_CLR: begin
              result   <= '0;
              chain    <= 1'b0;
              err_div0 <= 1'b0;
              ovf      <= 1'b0;
            end
            default: begin
              chain <= 1'b1;
            end
          endcase
        end

        ST_DIV: begin
          if (!diff[RW]) begin
            rem <= diff[RW-1:0];
            quo <= {quo[RW-2:0], 1'b1};
          end else begin
            rem <= shifted[RW-1:0];
            quo <= {quo[RW-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(RW - 1)) state <= ST_DONE;
        end

        ST_DONE: begin
          result <= (op == FN_DIV) ? quo : rem;
          chain  <= 1'b1;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.result   = result;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.chain    = chain;
  assign bus.err_div0 = err_div0;
  assign bus.ovf      = ovf;

endmodule

// File: tb/tb_calc_accum_seq.sv
// Directed plus randomized bench for calc_accum_seq with a short debounce.
module tb_calc_accum_seq;
  import calc_pkg::*;

  localparam int W   = 8;
  localparam int RW  = 32;
  localparam int DEB = 4;
  localparam int DIV_BUSY = RW + 2;

  logic clk_g = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_result;
  logic        m_chain;
  logic        m_ovf;
  logic        m_err;
  int          exp_busy;

  calc_accum_seq_if #(.W(W), .RW(RW)) bus ();

  calc_accum_seq #(
    .W          (W),
    .RW         (RW),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk_g (clk_g),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk_g = ~clk_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_result = '0;
    m_chain  = 1'b0;
    m_ovf    = 1'b0;
    m_err    = 1'b0;
  endtask

  // Calculator behaviour in plain wide arithmetic.
  task automatic model(input logic [2:0] f, input logic [7:0] n1, input logic [7:0] n2);
    logic [63:0] a, b, r;
    a = m_chain ? {32'h0, m_result} : {56'h0, n1};
    b = {56'h0, n2};
    exp_busy = 1;
    case (f)
      FN_ADD: begin r = a + b; m_result = r[31:0]; m_chain = 1; if (r > 64'hFFFF_FFFF) m_ovf = 1; end
      FN_SUB: begin if (a < b) m_ovf = 1; r = a - b; m_result = r[31:0]; m_chain = 1; end
      FN_MUL: begin r = a * b; m_result = r[31:0]; m_chain = 1; if ((r >> 32) != 0) m_ovf = 1; end
      FN_SQR: begin r = a * a; m_result = r[31:0]; m_chain = 1; if ((r >> 32) != 0) m_ovf = 1; end
      FN_DIV, FN_MOD: begin
        m_chain = 1;
        if (b == 0) m_err = 1;
        else begin
          exp_busy = DIV_BUSY;
          r = (f == FN_DIV) ? a / b : a % b;
          m_result = r[31:0];
        end
      end
      FN_CLR: model_reset();
      default: m_chain = 1;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_result"}, bus.result, m_result);
    check({tag, "_chain"}, bus.chain, m_chain);
    check({tag, "_ovf"}, bus.ovf, m_ovf);
    check({tag, "_err"}, bus.err_div0, m_err);
  endtask

  // One full press/release cycle with busy-length and output checks.
  task automatic do_op(input logic [2:0] f, input logic [7:0] n1, input logic [7:0] n2,
                       input string tag);
    bit seen;
    int busy_len;
    bus.func = f;
    bus.num1 = n1;
    bus.num2 = n2;
    model(f, n1, n2);
    bus.button = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_g);
      if (bus.busy) seen = 1;
    end
    check({tag, "_busy_seen"}, seen, 1);
    busy_len = 0;
    while (bus.busy && busy_len < 100) begin
      busy_len++;
      @(negedge clk_g);
    end
    check({tag, "_busy_len"}, busy_len, exp_busy);
    bus.button = 1'b0;
    repeat (12) @(negedge clk_g);
    check_outputs(tag);
  endtask

  initial begin
    bit          seen;
    bit          prev;
    int          rises;
    int          busy_len;
    logic [2:0]  rf;
    logic [7:0]  rn1, rn2;

    bus.button = 1'b0;
    bus.func   = FN_ADD;
    bus.num1   = '0;
    bus.num2   = '0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk_g);
    check("rst_result", bus.result, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_chain", bus.chain, 0);
    check("rst_err", bus.err_div0, 0);
    check("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_g);

    // Chained add
    do_op(FN_ADD, 8'h12, 8'h34, "add1");
    check("add1_const", bus.result, 32'h46);
    do_op(FN_ADD, 8'h99, 8'h01, "add2");
    check("add2_const", bus.result, 32'h47);

    // Bounce rejection: toggles too short to pass, then a held press
    bus.func = FN_ADD;
    bus.num2 = 8'h01;
    model(FN_ADD, 8'h00, 8'h01);
    rises = 0;
    prev  = bus.busy;
    for (int i = 0; i < 10; i++) begin
      bus.button = ~bus.button;
      repeat (2) begin
        @(negedge clk_g);
        if (bus.busy && !prev) rises++;
        prev = bus.busy;
      end
    end
    bus.button = 1'b1;
    repeat (30) begin
      @(negedge clk_g);
      if (bus.busy && !prev) rises++;
      prev = bus.busy;
    end
    bus.button = 1'b0;
    repeat (12) begin
      @(negedge clk_g);
      if (bus.busy && !prev) rises++;
      prev = bus.busy;
    end
    check("bounce_ops", rises, 1);
    check("bounce_result", bus.result, 32'h48);

    // Load 0xFF, then divide by 0x10 with a dropped press during busy
    do_op(FN_CLR, 8'h00, 8'h00, "clr1");
    do_op(FN_ADD, 8'hFF, 8'h00, "load_ff");
    bus.func = FN_DIV;
    bus.num2 = 8'h10;
    model(FN_DIV, 8'h00, 8'h10);
    bus.button = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_g);
      if (bus.busy) seen = 1;
    end
    check("div_busy_seen", seen, 1);
    busy_len = 0;
    while (bus.busy && busy_len < 100) begin
      busy_len++;
      if (busy_len == 2)  bus.button = 1'b0;
      if (busy_len == 12) bus.button = 1'b1;
      if (busy_len == 24) bus.button = 1'b0;
      @(negedge clk_g);
    end
    check("div_busy_len", busy_len, 34);
    bus.button = 1'b0;
    rises = 0;
    repeat (20) begin
      @(negedge clk_g);
      if (bus.busy) rises++;
    end
    check("div_press_dropped", rises, 0);
    check_outputs("div");
    check("div_const", bus.result, 32'h0F);

    do_op(FN_MOD, 8'h00, 8'h04, "mod");
    check("mod_const", bus.result, 32'h3);

    // Divide by zero, then clear
    do_op(FN_DIV, 8'h00, 8'h00, "div0");
    check("div0_const_res", bus.result, 32'h3);
    check("div0_const_err", bus.err_div0, 1);
    do_op(FN_CLR, 8'h00, 8'h00, "clr2");
    check("clr2_const_chain", bus.chain, 0);

    // Wrap on subtract
    do_op(FN_SUB, 8'h01, 8'h02, "sub_wrap");
    check("sub_const", bus.result, 32'hFFFF_FFFF);
    check("sub_const_ovf", bus.ovf, 1);

    // Build 0x10000 then square it
    do_op(FN_CLR, 8'h00, 8'h00, "clr3");
    do_op(FN_ADD, 8'h80, 8'h80, "b_add");
    do_op(FN_MUL, 8'h00, 8'h80, "b_mul1");
    do_op(FN_MUL, 8'h00, 8'h02, "b_mul2");
    check("build_const", bus.result, 32'h0001_0000);
    check("build_ovf", bus.ovf, 0);
    do_op(FN_SQR, 8'h00, 8'h00, "sqr");
    check("sqr_const", bus.result, 32'h0);
    check("sqr_const_ovf", bus.ovf, 1);

    // Reset during DIV
    bus.func = FN_DIV;
    bus.num2 = 8'h03;
    bus.button = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_g);
      if (bus.busy) seen = 1;
    end
    check("rdiv_busy_seen", seen, 1);
    repeat (10) @(negedge clk_g);
    rst_n = 1'b0;
    #1;
    check("rdiv_result", bus.result, 0);
    check("rdiv_busy", bus.busy, 0);
    check("rdiv_chain", bus.chain, 0);
    check("rdiv_err", bus.err_div0, 0);
    check("rdiv_ovf", bus.ovf, 0);
    model_reset();
    bus.button = 1'b0;
    repeat (2) @(negedge clk_g);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_g);
    do_op(FN_ADD, 8'h05, 8'h06, "post_rst");
    check("post_rst_const", bus.result, 32'd11);

    // Randomized operations against the model
    for (int i = 0; i < 30; i++) begin
      rf  = 3'($urandom_range(0, 7));
      rn1 = 8'($urandom);
      rn2 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_op(rf, rn1, rn2, $sformatf("rnd%0d_f%0d", i, rf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_accum_seq.md
# calc_accum_seq

Parametrised chained calculator for the board-level hex calculator path. A debounced push-button commits one operation per press. The first press after reset or clear computes `num1 op num2`; each later press computes `result op num2`. Division and modulo run on a sequential restoring divider, and the block reports busy, divide-by-zero and overflow status. Output feeds the 7-segment hex display driver.

## Interface
- `W`, 8: operand width of `num1`/`num2`.
- `RW`, 32: result/accumulator width; must be ≥ 2·W.
- `DEB_CYCLES`, 150000: consecutive stable cycles required to accept a button level change.
- `clk_g`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `button`  in  1  raw, bouncy push-button, active-high.
- `func`  in  3  000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 square, 110 clear, 111 reserved.
- `num1`  in  W  first operand; used only on the first op of a chain.
- `num2`  in  W  second operand.
- `result`  out  RW  accumulator.
- `busy`  out  1  high while an op is executing; presses are ignored while high.
- `chain`  out  1  low means the next op uses `num1`; high means it uses `result`.
- `err_div0`  out  1  sticky; set by div/mod with `num2`=0.
- `ovf`  out  1  sticky; set when the true result does not fit in RW bits.

## Operation
- **Reset values:** `result`=0, `busy`=0, `chain`=0, `err_div0`=0, `ovf`=0. The FSM goes to IDLE and the debouncer state clears, with the debounced level at 0.
- **Debounce:**
  - `button` passes through a 2-FF synchroniser.
  - A counter restarts whenever the synchronised level differs from the debounced level and then matches again.
  - After DEB_CYCLES consecutive differing cycles, the debounced level toggles.
  - A 0→1 transition of the debounced level emits a one-cycle `press` pulse.
- **Operand selection:** `func` and `num2` are sampled on the `press` cycle. Operand A is `num1` (zero-extended to RW) if `chain`=0, otherwise `result`.
- **FSM states:** IDLE, EXEC, DIV, DONE.
  - IDLE → EXEC on `press`.
  - EXEC, op ∈ {add, sub, mul, square, clear, reserved}: computes, writes `result`, sets `chain`=1 (clear sets it to 0), then → IDLE.
  - EXEC, op = div or mod with B ≠ 0: → DIV.
  - EXEC, op = div or mod with B = 0: `result` unchanged, `err_div0`←1, `chain`=1, → IDLE.
  - DIV runs RW iterations, one bit per cycle, then → DONE.
  - DONE writes the quotient (div) or remainder (mod) to `result`, sets `chain`=1, → IDLE.
- **Arithmetic:** all results are modulo 2^RW.
  - add: `ovf` on carry out.
  - sub: `ovf` on borrow (A<B), result wraps.
  - mul/square: `ovf` if any bit above RW−1 of the 2·RW product is nonzero.
- **Clear:** `result`←0, `chain`←0, `err_div0`←0, `ovf`←0.
- **Reserved (111):** no-op; `result` and flags are unchanged, `chain`←1.
- **Error flags:** `err_div0` and `ovf` clear only on reset or on a clear op.
- **Press while busy:** dropped, not queued.
- **Reset mid-divide:** aborts to the reset values immediately.

## Timing
- **Press latency:** 2 sync cycles + DEB_CYCLES to the rising debounced level, then `press` on the next cycle.
- **Single-cycle ops:** `press` in cycle t; `busy`=1 in cycle t+1 (EXEC); `result`/flags updated at the end of t+1; `busy`=0 in t+2.
- **div/mod:** `busy`=1 from t+1 through t+RW+2, with `result` updated at the end of the DONE cycle t+RW+2. Total busy = RW+2 cycles.
- **Divide by zero:** same 1-cycle busy as the single-cycle ops.
- **Back-to-back presses:** the earliest acceptable `press` is in the cycle after `busy` falls.

## Structure
- **Shared package `calc_pkg`:**
  - `func` encodings as localparams: FN_ADD, FN_SUB, FN_MUL, FN_DIV, FN_MOD, FN_SQR, FN_CLR, FN_RSV.
  - FSM state enum.
- **Sub-module `btn_debounce`:**
  - Parameter DEB_CYCLES.
  - Ports `clk_g`, `rst_n`, `btn_raw`, `level`, `press`.
  - Reusable by the display mode buttons.
- **Divider:** inline shift-subtract datapath of width RW in the top module.

## Test plan
Bench parameters: W=8, RW=32, DEB_CYCLES=4.
- **Chained add:** press add with num1=0x12, num2=0x34 → `result`=0x46, `chain`=1. Press again with num2=0x01 → 0x47.
- **Bounce rejection:** toggle `button` every 2 cycles for 20 cycles, then hold high → exactly one op executes. A press during `busy` (div) is ignored.
- **Divide:**
  - From `result`=0xFF, press div with num2=0x10 → `busy` high 34 cycles, `result`=0x0F.
  - Then press mod with num2=0x04 → `result`=3.
- **Divide by zero:** div with num2=0 → `result` unchanged, `err_div0`=1, `busy` 1 cycle. A following clear → `result`=0, `err_div0`=0, `chain`=0.
- **Overflow and wrap:**
  - sub with num1=0x01, num2=0x02 (chain=0) → `result`=0xFFFFFFFF, `ovf`=1.
  - From `result`=0x00010000, square → `result`=0, `ovf`=1.
- **Reset mid-divide:** assert `rst_n`=0 during DIV → all outputs take their reset values the same cycle. The next op uses `num1`.
